// File: rtl/kyber_pkg.sv
`default_nettype none
// ============================================================================
// Module : kyber_pkg
// Brief  : Shared Kyber constants and the round-robin next-index search.
// Rev    : 1.0 - initial release
// ============================================================================
package kyber_pkg;

    localparam int KYBER_Q = 3329;
    localparam int COEF_W  = 12;
    localparam int PROD_W  = 24;
    localparam int RR_MAX  = 4;

    // Returns {found, index}; the search starts at last+1 and wraps modulo nreq.
    // Iterating from the farthest offset down lets the nearest valid index win.
    function automatic logic [2:0] rr_next(
        input logic [3:0] valid,
        input logic [1:0] last,
        input logic [2:0] nreq
    );
        logic [2:0] res;
        logic [2:0] idx;
        res = '0;
        for (int k = RR_MAX; k >= 1; k--) begin
            idx = {1'b0, last} + 3'(k);
            if (idx >= nreq) begin
                idx = idx - nreq;
            end
            if ((k <= int'(nreq)) && valid[idx[1:0]]) begin
                res = {1'b1, idx[1:0]};
            end
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mul.sv
`default_nettype none
// ============================================================================
// Module : mul
// Brief  : Combinational 12x12 -> 24 unsigned multiplier, fabric only.
// Rev    : 1.0 - initial release
// ============================================================================
(* use_dsp = "no" *)
module mul
    import kyber_pkg::*;
(
    input  logic [COEF_W-1:0] a,
    input  logic [COEF_W-1:0] b,
    output logic [PROD_W-1:0] p
);

    assign p = PROD_W'(a) * PROD_W'(b);

endmodule
`default_nettype wire

// File: rtl/mul_share_arb.sv
`default_nettype none
// ============================================================================
// Module : mul_share_arb
// Brief  : Round-robin arbiter sharing one multiplier across NREQ requesters
//          through a fixed-latency, non-stalling pipeline.
// Rev    : 1.0 - initial release
// ============================================================================
module mul_share_arb
    import kyber_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int LAT  = 2,
    parameter int TAGW = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*COEF_W-1:0] req_a,
    input  logic [NREQ*COEF_W-1:0] req_b,
    input  logic [NREQ*TAGW-1:0]   req_tag,
    output logic [NREQ-1:0]        rsp_valid,
    output logic [PROD_W-1:0]      rsp_data,
    output logic [TAGW-1:0]        rsp_tag,
    output logic                   busy
);

    localparam logic [1:0] c_last_rst = 2'(NREQ - 1);

    logic [3:0]        w_valid4;
    logic [2:0]        w_pick;
    logic              w_hs;
    logic [NREQ-1:0]   w_grant;
    logic [COEF_W-1:0] w_a;
    logic [COEF_W-1:0] w_b;
    logic [TAGW-1:0]   w_tag;
    logic [PROD_W-1:0] w_prod;

    logic [1:0]        r_last;
    logic              r_v0;
    logic [NREQ-1:0]   r_oh0;
    logic [COEF_W-1:0] r_a0;
    logic [COEF_W-1:0] r_b0;
    logic [TAGW-1:0]   r_tag0;

    logic [LAT-1:1]    r_v;
    logic [NREQ-1:0]   r_oh   [1:LAT-1];
    logic [PROD_W-1:0] r_data [1:LAT-1];
    logic [TAGW-1:0]   r_tag  [1:LAT-1];

    always_comb begin
        w_valid4             = '0;
        w_valid4[NREQ-1:0]   = req_valid & {NREQ{en}};
    end

    assign w_pick = rr_next(w_valid4, r_last, 3'(NREQ));
    assign w_hs   = w_pick[2];

    always_comb begin
        w_grant = '0;
        w_a     = '0;
        w_b     = '0;
        w_tag   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_hs && (w_pick[1:0] == 2'(i))) begin
                w_grant[i] = 1'b1;
                w_a        = req_a[i*COEF_W +: COEF_W];
                w_b        = req_b[i*COEF_W +: COEF_W];
                w_tag      = req_tag[i*TAGW +: TAGW];
            end
        end
    end

    assign req_ready = w_grant;

    // Operands are captured only on a handshake; otherwise only the valid drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= c_last_rst;
            r_v0   <= 1'b0;
            r_oh0  <= '0;
            r_a0   <= '0;
            r_b0   <= '0;
            r_tag0 <= '0;
        end else begin
            r_v0 <= w_hs;
            if (w_hs) begin
                r_last <= w_pick[1:0];
                r_oh0  <= w_grant;
                r_a0   <= w_a;
                r_b0   <= w_b;
                r_tag0 <= w_tag;
            end
        end
    end

    mul u_mul (
        .a (r_a0),
        .b (r_b0),
        .p (w_prod)
    );

    // Payload registers move only with a valid entry so the outputs hold when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v <= '0;
            for (int s = 1; s < LAT; s++) begin
                r_oh[s]   <= '0;
                r_data[s] <= '0;
                r_tag[s]  <= '0;
            end
        end else begin
            r_v[1] <= r_v0;
            if (r_v0) begin
                r_oh[1]   <= r_oh0;
                r_data[1] <= w_prod;
                r_tag[1]  <= r_tag0;
            end
            for (int s = 2; s < LAT; s++) begin
                r_v[s] <= r_v[s-1];
                if (r_v[s-1]) begin
                    r_oh[s]   <= r_oh[s-1];
                    r_data[s] <= r_data[s-1];
                    r_tag[s]  <= r_tag[s-1];
                end
            end
        end
    end

    assign rsp_valid = r_oh[LAT-1] & {NREQ{r_v[LAT-1]}};
    assign rsp_data  = r_data[LAT-1];
    assign rsp_tag   = r_tag[LAT-1];
    assign busy      = r_v0 | (|r_v);

endmodule
`default_nettype wire

// File: tb/tb_mul_share_arb.sv
`default_nettype none
// ============================================================================
// Module : tb_mul_share_arb
// Brief  : Scoreboard bench for mul_share_arb with a reference round-robin model.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_mul_share_arb;

    localparam int NREQ = 2;
    localparam int LAT  = 2;
    localparam int TAGW = 8;

    typedef struct {
        logic [NREQ-1:0] oh;
        logic [23:0]     data;
        logic [TAGW-1:0] tag;
        int              due;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 en = 1'b0;
    logic [NREQ-1:0]      req_valid = '0;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*12-1:0]   req_a = '0;
    logic [NREQ*12-1:0]   req_b = '0;
    logic [NREQ*TAGW-1:0] req_tag = '0;
    logic [NREQ-1:0]      rsp_valid;
    logic [23:0]          rsp_data;
    logic [TAGW-1:0]      rsp_tag;
    logic                 busy;

    int              cyc = 0;
    int              n_cmp = 0;
    int              n_err = 0;
    int              n_acc = 0;
    int              m_last = NREQ - 1;
    logic [NREQ-1:0] exp_gnt = '0;
    exp_t            q[$];

    mul_share_arb #(.NREQ(NREQ), .LAT(LAT), .TAGW(TAGW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_tag   (req_tag),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_tag   (rsp_tag),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor + reference model: checks responses, busy and grants at every negedge.
    always @(negedge clk) begin : mon
        logic [NREQ-1:0] g;
        int              gi;
        int              idx;
        exp_t            e;
        if (!rst_n) begin
            q.delete();
            m_last  = NREQ - 1;
            exp_gnt = '0;
        end else begin
            check("busy", 64'(busy), 64'((q.size() > 0) && (q[0].due - LAT + 1 <= cyc)));
            if (rsp_valid != '0) begin
                if (q.size() > 0 && q[0].due == cyc) begin
                    e = q.pop_front();
                    check("rsp_valid", 64'(rsp_valid), 64'(e.oh));
                    check("rsp_data", 64'(rsp_data), 64'(e.data));
                    check("rsp_tag", 64'(rsp_tag), 64'(e.tag));
                end else begin
                    check("unexpected_rsp", 64'(rsp_valid), 64'(0));
                end
            end else if (q.size() > 0 && q[0].due <= cyc) begin
                e = q.pop_front();
                check("missing_rsp", 64'(rsp_valid), 64'(e.oh));
            end
            g  = '0;
            gi = -1;
            if (en) begin
                for (int k = 1; k <= NREQ; k++) begin
                    idx = (m_last + k) % NREQ;
                    if (gi < 0 && req_valid[idx]) gi = idx;
                end
            end
            if (gi >= 0) g[gi] = 1'b1;
            check("req_ready", 64'(req_ready), 64'(g));
            exp_gnt = g;
            if (gi >= 0) begin
                e.oh   = g;
                e.data = 24'(int'(req_a[gi*12 +: 12]) * int'(req_b[gi*12 +: 12]));
                e.tag  = req_tag[gi*TAGW +: TAGW];
                e.due  = cyc + LAT;
                q.push_back(e);
                m_last = gi;
                n_acc++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input int a, input int b, input int tg);
        req_valid[i]          = v;
        req_a[i*12 +: 12]     = 12'(a);
        req_b[i*12 +: 12]     = 12'(b);
        req_tag[i*TAGW +: TAGW] = TAGW'(tg);
    endtask

    initial begin : stim
        int n;
        int tg;
        int acc0;
        int c;

        // Reset state
        #3;
        check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_rsp_data", 64'(rsp_data), 64'(0));
        check("rst_rsp_tag", 64'(rsp_tag), 64'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        en    = 1'b1;
        tick();

        // Single request: 3328*3328 = 11075584
        set_req(0, 1'b1, 3328, 3328, 8'h11);
        #1;
        check("single_ready", 64'(req_ready), 64'(2'b01));
        tick();
        req_valid = '0;
        tick();
        tick();
        check("single_hold_data", 64'(rsp_data), 64'(24'd11075584));
        check("single_hold_tag", 64'(rsp_tag), 64'(8'h11));
        check("single_idle_valid", 64'(rsp_valid), 64'(0));
        tick();

        // Both continuously valid: a=n, b=n+1, fresh payload after each grant
        n  = 1;
        tg = 8'h20;
        for (int i = 0; i < NREQ; i++) begin
            set_req(i, 1'b1, n, n + 1, tg);
            n++;
            tg++;
        end
        for (int k = 0; k < 8; k++) begin
            tick();
            for (int i = 0; i < NREQ; i++) begin
                if (exp_gnt[i]) begin
                    set_req(i, 1'b1, n, n + 1, tg);
                    n++;
                    tg++;
                end
            end
        end
        req_valid = '0;
        repeat (LAT + 2) tick();

        // Max operands then zero operand
        set_req(0, 1'b1, 4095, 4095, 8'h40);
        tick();
        req_valid = '0;
        repeat (LAT + 1) tick();
        check("max_product", 64'(rsp_data), 64'(24'd16769025));
        set_req(1, 1'b1, 0, 4095, 8'h41);
        tick();
        req_valid = '0;
        repeat (LAT + 1) tick();
        check("zero_product", 64'(rsp_data), 64'(0));
        check("zero_tag", 64'(rsp_tag), 64'(8'h41));

        // en low blocks grants; resumes after last granted (req1)
        en = 1'b0;
        set_req(0, 1'b1, 100, 200, 8'h50);
        set_req(1, 1'b1, 300, 400, 8'h51);
        for (int k = 0; k < 4; k++) begin
            #1;
            check("en_low_ready", 64'(req_ready), 64'(0));
            tick();
        end
        check("en_low_no_rsp", 64'(rsp_valid), 64'(0));
        en = 1'b1;
        #1;
        check("en_resume_ready", 64'(req_ready), 64'(2'b01));
        tick();
        req_valid[0] = 1'b0;
        tick();
        req_valid = '0;
        repeat (LAT + 2) tick();

        // Reset mid-flight after two accepts
        set_req(0, 1'b1, 7, 9, 8'h60);
        set_req(1, 1'b1, 11, 13, 8'h61);
        tick();
        tick();
        req_valid = '0;
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("midrst_busy", 64'(busy), 64'(0));
        check("midrst_rsp_data", 64'(rsp_data), 64'(0));
        check("midrst_rsp_tag", 64'(rsp_tag), 64'(0));
        tick();
        tick();
        rst_n = 1'b1;
        repeat (4) tick();
        check("midrst_quiet", 64'(rsp_valid), 64'(0));
        set_req(0, 1'b1, 5, 6, 8'h70);
        set_req(1, 1'b1, 8, 9, 8'h71);
        #1;
        check("midrst_first_grant", 64'(req_ready), 64'(2'b01));
        tick();
        req_valid = '0;
        repeat (LAT + 2) tick();

        // Randomized back-to-back traffic, 1000 accepts
        acc0 = n_acc;
        tg   = 0;
        c    = 0;
        while ((n_acc - acc0) < 1000 && c < 20000) begin
            for (int i = 0; i < NREQ; i++) begin
                if (exp_gnt[i] || !req_valid[i]) begin
                    if ($urandom_range(0, 3) != 0) begin
                        set_req(i, 1'b1, int'($urandom_range(0, 4095)),
                                int'($urandom_range(0, 4095)), tg);
                        tg++;
                    end else begin
                        req_valid[i] = 1'b0;
                    end
                end
            end
            tick();
            c++;
        end
        req_valid = '0;
        repeat (LAT + 3) tick();
        check("rand_accepts", 64'((n_acc - acc0) >= 1000), 64'(1));
        check("scoreboard_empty", 64'(q.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
